fifo_serial_tx: RTL and testbench

FIFO_SERIAL_TX -- requirements
Module: fifo_serial_tx

---
 rtl/fifo_pkg.sv | 36 +++
 rtl/fifo_tx_baud.sv | 48 ++++
 rtl/fifo_serial_tx.sv | 193 +++++++++++++++++++
 tb/tb_fifo_serial_tx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the fifo-fed serial transmitter:
//   - state_t    : transmitter FSM state encoding
//   - DATA_W     : payload bits per frame (8)
//   - START_BITS : start bits per frame (1)
//   - STOP_BITS  : stop bits per frame (1)
//   - BIT_CNT_W  : width of the in-state bit counter
//   - even_parity: XOR reduction of a payload byte
// Optional feature macro: FIFO_TX_PARITY_EN adds the ST_PARITY state.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned START_BITS = 1;
  localparam int unsigned STOP_BITS  = 1;
  localparam int unsigned BIT_CNT_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_START   = 3'd3,
    ST_DATA    = 3'd4,
`ifdef FIFO_TX_PARITY_EN
    ST_PARITY  = 3'd5,
`endif
    ST_STOP    = 3'd6
  } state_t;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/fifo_tx_baud.sv
// -----------------------------------------------------------------------------
// fifo_tx_baud
// Bit-period timer. Counts CLKS_PER_BIT clocks per serial bit and flags the
// last clock of each bit period with 'tick'.
// Ports:
//   clk     in  : clock, all logic on posedge
//   reset   in  : synchronous active-high reset (counter cleared to 0)
//   restart in  : reload the period; next cycle is the first clock of a bit
//   tick    out : high in the last clock of the current bit period
// -----------------------------------------------------------------------------
module fifo_tx_baud #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam logic [7:0] RELOAD = 8'(CLKS_PER_BIT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Down-counter: reload on restart or when a period expires.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = RELOAD;
    end else if (cnt_q == 8'd0) begin
      cnt_d = RELOAD;
    end else begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == 8'd0);

endmodule

// File: rtl/fifo_serial_tx.sv
// -----------------------------------------------------------------------------
// fifo_serial_tx
// Pulls bytes from an upstream 8-bit fifo and shifts them out as asynchronous
// serial frames: start(0), 8 data bits LSB first, [even parity], stop(1).
// Optional feature macro: FIFO_TX_PARITY_EN (adds the parity bit, 11-bit frame;
// default build sends 10-bit frames).
// Ports:
//   clk          in  : clock, all logic on posedge
//   reset        in  : synchronous active-high reset, aborts any frame
//   fifo_empty   in  : upstream fifo empty flag
//   fifo_rd_data in  : upstream read data, valid the cycle after fifo_rd_req
//   fifo_rd_req  out : one-cycle read pulse per byte (registered)
//   tx_enable    in  : permits new frames to start
//   tx           out : serial line, idles high (registered)
//   busy         out : high whenever the FSM is not idle (registered)
//   bytes_sent   out : wrapping count of completed frames
// -----------------------------------------------------------------------------
module fifo_serial_tx
  import fifo_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_rd_data,
  output logic             fifo_rd_req,
  input  logic             tx_enable,
  output logic             tx,
  output logic             busy,
  output logic [CNT_W-1:0] bytes_sent
);

  state_t               state_q;
  state_t               state_d;
  logic [DATA_W-1:0]    shift_q;
  logic [DATA_W-1:0]    shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [BIT_CNT_W-1:0] bit_cnt_d;
  logic                 tx_q;
  logic                 tx_d;
  logic                 rd_req_q;
  logic                 busy_q;
  logic [CNT_W-1:0]     bytes_q;
  logic [CNT_W-1:0]     bytes_d;
  logic                 tick_s;
  logic                 restart_s;
  logic                 can_start_s;

  // Every state entry restarts the bit period, so each state starts on a
  // full-length bit regardless of where the free-running count was.
  assign restart_s   = (state_d != state_q);
  assign can_start_s = tx_enable & ~fifo_empty;

  fifo_tx_baud #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .restart (restart_s),
    .tick    (tick_s)
  );

  // Next-state and next-output logic. tx_d is the line value for the
  // following cycle, so tx changes exactly on the state/bit boundary.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    bytes_d   = bytes_q;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (can_start_s) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        tx_d    = 1'b1;
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        shift_d   = fifo_rd_data;
        bit_cnt_d = {BIT_CNT_W{1'b0}};
        tx_d      = 1'b0;
        state_d   = ST_START;
      end
      ST_START: begin
        if (tick_s) begin
          if (bit_cnt_q == BIT_CNT_W'(START_BITS - 1)) begin
            state_d   = ST_DATA;
            bit_cnt_d = {BIT_CNT_W{1'b0}};
            tx_d      = shift_q[0];
          end else begin
            bit_cnt_d = bit_cnt_q + {{(BIT_CNT_W-1){1'b0}}, 1'b1};
            tx_d      = 1'b0;
          end
        end else begin
          tx_d = 1'b0;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          if (bit_cnt_q == BIT_CNT_W'(DATA_W - 1)) begin
            bit_cnt_d = {BIT_CNT_W{1'b0}};
`ifdef FIFO_TX_PARITY_EN
            // Rotation preserves the XOR of the byte, so parity is still
            // available from the shift register here.
            state_d = ST_PARITY;
            tx_d    = even_parity(shift_q);
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            // Rotate rather than shift so the byte stays intact.
            bit_cnt_d = bit_cnt_q + {{(BIT_CNT_W-1){1'b0}}, 1'b1};
            shift_d   = {shift_q[0], shift_q[DATA_W-1:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          tx_d = tx_q;
        end
      end
`ifdef FIFO_TX_PARITY_EN
      ST_PARITY: begin
        if (tick_s) begin
          state_d   = ST_STOP;
          bit_cnt_d = {BIT_CNT_W{1'b0}};
          tx_d      = 1'b1;
        end else begin
          tx_d = tx_q;
        end
      end
`endif
      ST_STOP: begin
        tx_d = 1'b1;
        if (tick_s) begin
          if (bit_cnt_q == BIT_CNT_W'(STOP_BITS - 1)) begin
            bytes_d   = bytes_q + {{(CNT_W-1){1'b0}}, 1'b1};
            bit_cnt_d = {BIT_CNT_W{1'b0}};
            // Back-to-back frames skip IDLE entirely.
            if (can_start_s) begin
              state_d = ST_REQ;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + {{(BIT_CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        tx_d      = 1'b1;
        bit_cnt_d = {BIT_CNT_W{1'b0}};
      end
    endcase
  end

  // State and registered outputs; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= {DATA_W{1'b0}};
      bit_cnt_q <= {BIT_CNT_W{1'b0}};
      tx_q      <= 1'b1;
      rd_req_q  <= 1'b0;
      busy_q    <= 1'b0;
      bytes_q   <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rd_req_q  <= (state_d == ST_REQ);
      busy_q    <= (state_d != ST_IDLE);
      bytes_q   <= bytes_d;
    end
  end

  assign fifo_rd_req = rd_req_q;
  assign tx          = tx_q;
  assign busy        = busy_q;
  assign bytes_sent  = bytes_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_serial_tx
// Self-checking bench for fifo_serial_tx. A queue-based fifo and a frame-level
// reference model predict tx / fifo_rd_req / busy / bytes_sent every cycle;
// directed scenarios add explicit waveform checks, then random traffic runs.
// -----------------------------------------------------------------------------
module tb_fifo_serial_tx;

  localparam int C  = 4;
  localparam int CW = 16;
`ifdef FIFO_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif

  logic          clk          = 1'b0;
  logic          reset        = 1'b1;
  logic          fifo_empty   = 1'b1;
  logic [7:0]    fifo_rd_data = 8'h00;
  logic          tx_enable    = 1'b0;
  logic          fifo_rd_req;
  logic          tx;
  logic          busy;
  logic [CW-1:0] bytes_sent;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0]    fq[$];
  logic [1:0]    expq[$];
  logic [CW-1:0] model_cnt = '0;
  bit            exp_rd    = 1'b0;
  bit            prev_rd   = 1'b0;
  bit            decide_q  = 1'b0;

  logic tr[0:199];
  logic bz[0:199];
  int   rq[$];

  fifo_serial_tx #(
    .CLKS_PER_BIT (C),
    .CNT_W        (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_req  (fifo_rd_req),
    .tx_enable    (tx_enable),
    .tx           (tx),
    .busy         (busy),
    .bytes_sent   (bytes_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    fifo_empty = 1'b0;
  endtask

  // Expected line value per cycle, from the CAPTURE cycle to the last stop cycle.
  task automatic build_frame(input logic [7:0] b);
    expq.push_back(2'b01);
    for (int i = 0; i < C; i++) expq.push_back(2'b00);
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < C; i++) expq.push_back({1'b0, b[j]});
`ifdef FIFO_TX_PARITY_EN
    for (int i = 0; i < C; i++) expq.push_back({1'b0, ^b});
`endif
    for (int i = 0; i < C - 1; i++) expq.push_back(2'b01);
    expq.push_back(2'b11);
  endtask

  // One clock: check outputs against the model, then update fifo and model.
  task automatic tick();
    logic [1:0] cur;
    bit         had;
    @(negedge clk);
    cyc++;
    if (reset) begin
      expq.delete();
      model_cnt = '0;
      if (prev_rd && fq.size() > 0) fifo_rd_data = fq.pop_front();
      fifo_empty = (fq.size() == 0);
      prev_rd    = 1'b0;
      exp_rd     = 1'b0;
    end else begin
      exp_rd = decide_q && tx_enable && !fifo_empty;
    end
    had = (expq.size() > 0);
    cur = had ? expq.pop_front() : 2'b01;
    chk("tx", 32'(tx), 32'(cur[0]));
    chk("rd_req", 32'(fifo_rd_req), 32'(exp_rd));
    chk("busy", 32'(busy), 32'(exp_rd || had));
    chk("bytes_sent", 32'(bytes_sent), 32'(model_cnt));
    if (had && cur[1]) model_cnt++;
    if (exp_rd) build_frame(fq[0]);
    if (prev_rd) begin
      fifo_rd_data = fq.pop_front();
      fifo_empty   = (fq.size() == 0);
    end else begin
      fifo_rd_data = 8'($urandom);
    end
    prev_rd  = exp_rd;
    decide_q = (expq.size() == 0);
  endtask

  task automatic record(input int n);
    rq.delete();
    for (int i = 0; i < n; i++) begin
      tick();
      tr[i] = tx;
      bz[i] = busy;
      if (fifo_rd_req === 1'b1) rq.push_back(i);
    end
  endtask

  task automatic wait_rdreq(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      if (fifo_rd_req === 1'b1) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    logic [9:0] pat;
    int         r;
    int         lows;
    logic [CW-1:0] base;

    // Reset state
    for (int i = 0; i < 3; i++) tick();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_rdreq", 32'(fifo_rd_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bytes", 32'(bytes_sent), 32'd0);
    reset = 1'b0;

    // Single byte 0xA5: line sequence 0,1,0,1,0,0,1,0,1,1
    tx_enable = 1'b1;
    push(8'hA5);
    record(60);
    chk("a5_rdreq_cnt", 32'(rq.size()), 32'd1);
    if (rq.size() > 0) begin
      r   = rq[0];
      pat = 10'b11_0100_1010;
      chk("a5_capture_high", 32'(tr[r+1]), 32'd1);
      for (int b = 0; b < 10; b++)
        for (int k = 0; k < C; k++)
          chk($sformatf("a5_bit%0d", b), 32'(tr[r+2+b*C+k]), 32'(pat[b]));
    end
    chk("a5_bytes", 32'(bytes_sent), 32'd1);

    // Back-to-back 0x01, 0xFF: no idle between frames
    push(8'h01);
    push(8'hFF);
    record(120);
    chk("b2b_rdreq_cnt", 32'(rq.size()), 32'd2);
    if (rq.size() == 2) begin
      chk("b2b_gap", 32'(rq[1] - rq[0]), 32'(FRAME * C + 2));
      lows = 0;
      for (int i = rq[0]; i <= rq[1]; i++) if (!bz[i]) lows++;
      chk("b2b_busy_gap", 32'(lows), 32'd0);
      chk("b2b_stop_then_start", 32'({tr[rq[1]-1], tr[rq[1]+2]}), 32'b10);
    end
    chk("b2b_bytes", 32'(bytes_sent), 32'd3);

    // Empty fifo with enable: nothing happens
    record(100);
    lows = 0;
    for (int i = 0; i < 100; i++) if (!tr[i] || bz[i]) lows++;
    chk("empty_rdreq_cnt", 32'(rq.size()), 32'd0);
    chk("empty_quiet", 32'(lows), 32'd0);

    // Enable dropped during the 3rd data bit of 0x3C
    base = model_cnt;
    push(8'h3C);
    push(8'h55);
    wait_rdreq("drop_rdreq_timeout");
    for (int i = 0; i < 3 * C + 3; i++) tick();
    tx_enable = 1'b0;
    record(60);
    chk("drop_no_rdreq", 32'(rq.size()), 32'd0);
    chk("drop_bytes", 32'(bytes_sent), 32'(base + 1'b1));
    chk("drop_idle", 32'(busy), 32'd0);
    tx_enable = 1'b1;
    record(60);
    chk("drop_resume_rdreq", 32'(rq.size()), 32'd1);

    // Reset during DATA aborts the frame
    push(8'h96);
    push(8'h5A);
    wait_rdreq("rst_rdreq_timeout");
    for (int i = 0; i < C + 7; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_bytes", 32'(bytes_sent), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    record(60);
    chk("midrst_restart_rdreq", 32'(rq.size()), 32'd1);
    chk("midrst_restart_bytes", 32'(bytes_sent), 32'd1);

`ifdef FIFO_TX_PARITY_EN
    // Parity bit: 0x07 -> 1, 0x03 -> 0
    push(8'h07);
    wait_rdreq("par07_timeout");
    record(50);
    chk("par07_parity", 32'(tr[1+9*C+1]), 32'd1);
    chk("par07_stop", 32'(tr[1+10*C]), 32'd1);
    push(8'h03);
    wait_rdreq("par03_timeout");
    record(50);
    chk("par03_parity", 32'(tr[1+9*C+1]), 32'd0);
    chk("par03_stop", 32'(tr[1+10*C]), 32'd1);
`else
    // No parity slot: stop follows the last data bit directly
    push(8'h00);
    wait_rdreq("nopar_timeout");
    record(50);
    chk("nopar_last_data", 32'(tr[9*C]), 32'd0);
    chk("nopar_stop", 32'(tr[1+9*C]), 32'd1);
`endif

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0 && fq.size() < 6) push(8'($urandom));
      if ($urandom_range(0, 19) == 0) tx_enable = ~tx_enable;
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset     = 1'b0;
    tx_enable = 1'b1;
    for (int i = 0; i < 400; i++) tick();
    chk("drain_fifo_empty", 32'(fq.size()), 32'd0);
    chk("drain_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
